// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue unit.
//   OPC_W/OPD_W/RES_W : opcode, operand and result widths of the attached ALU
//   alu_cmd_t         : one queued ALU command {opcode, a, b}
//   alu_state_e       : issue FSM states
package alu_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned OPD_W = 4;
    localparam int unsigned RES_W = 6;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OPD_W-1:0] a;
        logic [OPD_W-1:0] b;
    } alu_cmd_t;

    localparam int unsigned CMD_W = $bits(alu_cmd_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_issue_unit_fifo.sv
// Synchronous FIFO used as the command queue of the ALU issue unit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : write request and data (ignored while full)
//   pop, rdata  : read request (ignored while empty); rdata shows the head entry
//   full, empty : registered status flags
//   count       : current occupancy
module sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Flags are registered from the next count so cmd_ready never depends on
    // a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = cnt_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit for a clocked 4-bit ALU. Buffers commands in a FIFO, drives one
// command at a time onto the registered ALU inputs, waits ALU_LAT edges,
// captures the ALU result and offers it with its opcode on a valid/ready port.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*       : command input handshake and payload
//   alu_opcode/alu_a/alu_b           : registered ALU inputs
//   alu_result                       : ALU output
//   res_valid/res_ready, res_*       : result output handshake and payload
//   busy                             : FSM active or commands queued
//   count                            : FIFO occupancy
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OPC_W-1:0]         cmd_opcode,
    input  logic [OPD_W-1:0]         cmd_a,
    input  logic [OPD_W-1:0]         cmd_b,
    output logic [OPC_W-1:0]         alu_opcode,
    output logic [OPD_W-1:0]         alu_a,
    output logic [OPD_W-1:0]         alu_b,
    input  logic [RES_W-1:0]         alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [OPC_W-1:0]         res_opcode,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned WCNT_W = $clog2(ALU_LAT + 1);

    alu_cmd_t          push_cmd, head_cmd;
    logic              fifo_full, fifo_empty;
    logic              issue, capture, res_done;

    alu_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [OPC_W-1:0]  alu_opcode_q, tag_q, res_opcode_q;
    logic [OPD_W-1:0]  alu_a_q, alu_b_q;
    logic [RES_W-1:0]  res_data_q;
    logic              res_valid_q;

    assign push_cmd = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (push_cmd),
        .pop   (issue),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        capture  = 1'b0;
        res_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_done = 1'b1;
                    // Back-to-back: hand over the result and issue next in one edge.
                    if (!fifo_empty) begin
                        issue   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            tag_q        <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                alu_opcode_q <= head_cmd.opcode;
                alu_a_q      <= head_cmd.a;
                alu_b_q      <= head_cmd.b;
                tag_q        <= head_cmd.opcode;
                wcnt_q       <= WCNT_W'(ALU_LAT);
            end else if (state_q == WAIT && wcnt_q != '0) begin
                wcnt_q <= wcnt_q - 1'b1;
            end
            if (capture) begin
                res_valid_q  <= 1'b1;
                res_data_q   <= alu_result;
                res_opcode_q <= tag_q;
            end else if (res_done) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready  = !fifo_full;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_opcode = res_opcode_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ALU_LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_opcode = '0, cmd_a = '0, cmd_b = '0;
    logic [3:0] alu_opcode, alu_a, alu_b;
    logic [5:0] alu_result;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_data;
    logic [3:0] res_opcode;
    logic       busy;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int n_acc    = 0;
    int n_res    = 0;
    int max_cnt  = 0;
    int rises[$];
    logic prev_rv = 1'b0;
    logic [9:0] exp_q[$];  // {opcode, expected result} in issue order

    always #5 clk = ~clk;

    alu_issue_unit #(
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_opcode (res_opcode),
        .busy       (busy),
        .count      (count)
    );

    // ALU stand-in: zero-extended A plus B through ALU_LAT register stages.
    logic [5:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= {2'b00, alu_a} + {2'b00, alu_b};
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are sampled on the falling edge, state #1 after the rising edge.
    task automatic tick();
        logic acc, rhs;
        logic [9:0] e;
        @(negedge clk);
        acc = cmd_valid && cmd_ready;
        rhs = res_valid && res_ready;
        if (acc) begin
            exp_q.push_back({cmd_opcode, 6'(int'(cmd_a) + int'(cmd_b))});
            n_acc++;
        end
        if (rhs) begin
            n_res++;
            if (exp_q.size() == 0) begin
                check("result_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_res_opcode", 32'(res_opcode), 32'(e[9:6]));
                check("sb_res_data", 32'(res_data), 32'(e[5:0]));
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (res_valid && !prev_rv) rises.push_back(cycle);
        prev_rv = res_valid;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_opcode"}, 32'(res_opcode), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(n < 500), 32'd1);
    endtask

    task automatic rand_cmd();
        cmd_opcode = 4'($urandom_range(15));
        cmd_a      = 4'($urandom_range(15));
        cmd_b      = 4'($urandom_range(15));
    endtask

    initial begin
        int n, base_acc, base_res;
        logic [5:0] held;
        logic [3:0] ops [6];
        ops = '{4'b0000, 4'b0100, 4'b1000, 4'b1100, 4'b0001, 4'b0010};

        // Reset state
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_count", 32'(count), 32'd0);

        // Single command
        cmd_valid = 1'b1; cmd_opcode = 4'b0000; cmd_a = 4'd5; cmd_b = 4'd1;
        tick();
        cmd_valid = 1'b0;
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_alu_a_before_issue", 32'(alu_a), 32'd0);
        tick();
        check("single_alu_a", 32'(alu_a), 32'd5);
        check("single_alu_b", 32'(alu_b), 32'd1);
        check("single_alu_opcode", 32'(alu_opcode), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("single_latency", 32'(n), 32'(ALU_LAT + 1));
        check("single_res_data", 32'(res_data), 32'd6);
        check("single_res_opcode", 32'(res_opcode), 32'd0);
        tick();
        tick();
        check("single_hold_valid", 32'(res_valid), 32'd1);
        check("single_hold_data", 32'(res_data), 32'd6);
        res_ready = 1'b1;
        tick();
        check("single_consumed", 32'(res_valid), 32'd0);
        check("single_idle", 32'(busy), 32'd0);

        // Burst of 6 with res_ready held high
        rises.delete();
        max_cnt = 0;
        base_res = n_res;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_opcode = ops[i]; cmd_a = 4'd5; cmd_b = 4'd1;
            tick();
        end
        cmd_valid = 1'b0;
        drain("burst");
        check("burst_results", 32'(n_res - base_res), 32'd6);
        check("burst_rises", 32'(rises.size()), 32'd6);
        for (int i = 1; i < rises.size(); i++)
            check("burst_spacing", 32'(rises[i] - rises[i-1]), 32'(ALU_LAT + 2));
        check("burst_peak_le5", 32'(max_cnt <= 5), 32'd1);

        // Fill FIFO under back-pressure
        res_ready = 1'b0;
        base_acc = n_acc;
        base_res = n_res;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            cmd_valid = 1'b1;
            rand_cmd();
            tick();
        end
        check("full_accepted", 32'(n_acc - base_acc), 32'(DEPTH + 1));
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_res_valid", 32'(res_valid), 32'd1);
        held = res_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_res_data_stable", 32'(res_data), 32'(held));
        end
        check("full_no_extra_accept", 32'(n_acc - base_acc), 32'(DEPTH + 1));
        cmd_valid = 1'b0;

        // Back-pressure release
        res_ready = 1'b1;
        tick();
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        drain("release");
        check("release_results", 32'(n_res - base_res), 32'(DEPTH + 1));
        check("release_busy", 32'(busy), 32'd0);
        check("release_count", 32'(count), 32'd0);

        // Reset in WAIT with 3 entries queued
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        rand_cmd();
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("rstmid_first_result", 32'(res_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            rand_cmd();
            tick();
        end
        cmd_valid = 1'b0;
        check("rstmid_count4", 32'(count), 32'd4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("rstmid_count3", 32'(count), 32'd3);
        check("rstmid_waiting", 32'(res_valid), 32'd0);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rstmid");
        exp_q.delete();
        rises.delete();
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rstmid_no_result", 32'(rises.size()), 32'd0);
        check("rstmid_count_after", 32'(count), 32'd0);
        check("rstmid_busy_after", 32'(busy), 32'd0);

        // Pointer wrap with random stalls
        base_acc = n_acc;
        base_res = n_res;
        n = 0;
        while (((n_acc - base_acc) < 3 * int'(DEPTH) || exp_q.size() != 0) && n < 3000) begin
            cmd_valid = ((n_acc - base_acc) < 3 * int'(DEPTH)) && ($urandom_range(3) != 0);
            rand_cmd();
            res_ready = ($urandom_range(2) != 0);
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        check("wrap_finished", 32'(n < 3000), 32'd1);
        check("wrap_accepted", 32'(n_acc - base_acc), 32'(3 * DEPTH));
        check("wrap_results", 32'(n_res - base_res), 32'(3 * DEPTH));
        for (int i = 0; i < 4; i++) tick();
        check("wrap_final_busy", 32'(busy), 32'd0);
        check("wrap_final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
